// File: rtl/arbiter.sv
`default_nettype none
// ============================================================================
// Module      : arbiter
// Description : Two-requester arbiter with registered one-hot grants, fixed
//               priority to requester 0 and optional hold-limit preemption.
//               Define ARBITER_RR_EN for round-robin tie-break in IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module arbiter #(
    parameter int unsigned HOLD_MAX = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req_0,
    input  logic req_1,
    output logic gnt_0,
    output logic gnt_1
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    localparam bit              c_hold_en   = (HOLD_MAX != 0);
    localparam logic [CNT_W-1:0] c_hold_last = c_hold_en ? CNT_W'(HOLD_MAX - 1) : '0;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             w_hold_expire;
    logic             w_other_req;
    logic             w_tie_to_1;

`ifdef ARBITER_RR_EN
    // 1 = requester 0 won the most recent grant; reset value means requester 1 did.
    logic r_last_was_0;
    assign w_tie_to_1 = r_last_was_0;
`else
    assign w_tie_to_1 = 1'b0;
`endif

    assign w_hold_expire = c_hold_en && (r_hold_cnt == c_hold_last);
    assign w_other_req   = (r_state == ST_GNT0) ? req_1 :
                           (r_state == ST_GNT1) ? req_0 : 1'b0;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_0 && req_1)
                    w_next = w_tie_to_1 ? ST_GNT1 : ST_GNT0;
                else if (req_0)
                    w_next = ST_GNT0;
                else if (req_1)
                    w_next = ST_GNT1;
                else
                    w_next = ST_IDLE;
            end
            // Holder release always passes through IDLE, even if the other side waits.
            ST_GNT0: begin
                if (!req_0)
                    w_next = ST_IDLE;
                else if (req_1 && w_hold_expire)
                    w_next = ST_GNT1;
                else
                    w_next = ST_GNT0;
            end
            ST_GNT1: begin
                if (!req_1)
                    w_next = ST_IDLE;
                else if (req_0 && w_hold_expire)
                    w_next = ST_GNT0;
                else
                    w_next = ST_GNT1;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            gnt_0      <= 1'b0;
            gnt_1      <= 1'b0;
            r_hold_cnt <= '0;
`ifdef ARBITER_RR_EN
            r_last_was_0 <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            gnt_0   <= (w_next == ST_GNT0);
            gnt_1   <= (w_next == ST_GNT1);

            // Counter only advances while the same holder is contested.
            if (!c_hold_en || (w_next != r_state) || !w_other_req)
                r_hold_cnt <= '0;
            else if (r_hold_cnt != {CNT_W{1'b1}})
                r_hold_cnt <= r_hold_cnt + CNT_W'(1);

`ifdef ARBITER_RR_EN
            if (w_next != r_state) begin
                if (w_next == ST_GNT0)
                    r_last_was_0 <= 1'b1;
                else if (w_next == ST_GNT1)
                    r_last_was_0 <= 1'b0;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_arbiter
// Description : Scoreboard bench for arbiter; runs a default instance and a
//               HOLD_MAX=4 instance side by side on shared stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arbiter;

`ifdef ARBITER_RR_EN
    localparam bit c_rr = 1'b1;
`else
    localparam bit c_rr = 1'b0;
`endif

    logic clk;
    logic rst;
    logic req_0;
    logic req_1;
    logic gnt_0_m, gnt_1_m;
    logic gnt_0_h, gnt_1_h;

    int checks;
    int errors;

    // Entry: {main gnt_0, main gnt_1, hold gnt_0, hold gnt_1}
    logic [3:0] sb_q[$];

    arbiter u_dut_main (
        .clk   (clk),
        .rst   (rst),
        .req_0 (req_0),
        .req_1 (req_1),
        .gnt_0 (gnt_0_m),
        .gnt_1 (gnt_1_m)
    );

    arbiter #(.HOLD_MAX(4), .CNT_W(16)) u_dut_hold (
        .clk   (clk),
        .rst   (rst),
        .req_0 (req_0),
        .req_1 (req_1),
        .gnt_0 (gnt_0_h),
        .gnt_1 (gnt_1_h)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every cycle: grants mutually exclusive and only to a requester sampled high.
    always @(posedge clk) begin
        logic p0, p1;
        p0 = req_0;
        p1 = req_1;
        #1;
        checks = checks + 2;
        if ((gnt_0_m & gnt_1_m) !== 1'b0 || (gnt_0_h & gnt_1_h) !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL mutex t=%0t main=%b%b hold=%b%b required not both 1",
                     $time, gnt_0_m, gnt_1_m, gnt_0_h, gnt_1_h);
        end
        if (((gnt_0_m | gnt_0_h) && !p0) || ((gnt_1_m | gnt_1_h) && !p1)) begin
            errors = errors + 1;
            $display("FAIL grant_without_req t=%0t main=%b%b hold=%b%b req=%b%b",
                     $time, gnt_0_m, gnt_1_m, gnt_0_h, gnt_1_h, p0, p1);
        end
    end

    task automatic step(input logic r0, input logic r1,
                        input logic [1:0] e_main, input logic [1:0] e_hold,
                        input string name);
        logic [3:0] exp;
        sb_q.push_back({e_main, e_hold});
        req_0 = r0;
        req_1 = r1;
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        checks = checks + 2;
        if ({gnt_0_m, gnt_1_m} !== exp[3:2]) begin
            errors = errors + 1;
            $display("FAIL %s main t=%0t got %b%b expected %b", name, $time,
                     gnt_0_m, gnt_1_m, exp[3:2]);
        end
        if ({gnt_0_h, gnt_1_h} !== exp[1:0]) begin
            errors = errors + 1;
            $display("FAIL %s hold t=%0t got %b%b expected %b", name, $time,
                     gnt_0_h, gnt_1_h, exp[1:0]);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        req_0 = 1'b0;
        req_1 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 2'b00, 2'b00, "reset_hold");
        rst = 1'b1;
        step(1'b1, 1'b1, 2'b10, 2'b10, "reset_release");
        step(1'b0, 1'b0, 2'b00, 2'b00, "reset_idle");
    endtask

    task automatic test_single();
        do_reset();
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 2'b10, 2'b10, "single_on");
        step(1'b0, 1'b0, 2'b00, 2'b00, "single_off");
        step(1'b0, 1'b0, 2'b00, 2'b00, "single_idle");
    endtask

    task automatic test_tie();
        logic [1:0] e;
        do_reset();
        step(1'b1, 1'b1, 2'b10, 2'b10, "tie_first");
        step(1'b0, 1'b1, 2'b00, 2'b00, "tie_dead_cycle");
        step(1'b0, 1'b1, 2'b01, 2'b01, "tie_then_1");
        step(1'b0, 1'b1, 2'b01, 2'b01, "tie_keep_1");
        step(1'b0, 1'b0, 2'b00, 2'b00, "tie_release");
        do_reset();
        step(1'b1, 1'b1, 2'b10, 2'b10, "tie2_first");
        step(1'b0, 1'b0, 2'b00, 2'b00, "tie2_idle");
        e = c_rr ? 2'b01 : 2'b10;
        step(1'b1, 1'b1, e, e, "tie2_second");
        step(1'b0, 1'b0, 2'b00, 2'b00, "tie2_release");
    endtask

    task automatic test_hold();
        do_reset();
        step(1'b1, 1'b1, 2'b10, 2'b10, "hold_enter");
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 2'b10, 2'b10, "hold_count");
        step(1'b1, 1'b1, 2'b10, 2'b01, "hold_preempt_to_1");
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 2'b10, 2'b01, "hold_count_1");
        step(1'b1, 1'b1, 2'b10, 2'b10, "hold_preempt_to_0");
        step(1'b1, 1'b1, 2'b10, 2'b10, "hold_partial_a");
        step(1'b1, 1'b1, 2'b10, 2'b10, "hold_partial_b");
        step(1'b1, 1'b0, 2'b10, 2'b10, "hold_other_drop");
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 2'b10, 2'b10, "hold_after_clear");
        step(1'b1, 1'b1, 2'b10, 2'b01, "hold_preempt_again");
        step(1'b0, 1'b0, 2'b00, 2'b00, "hold_release");
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1'b0, 1'b1, 2'b01, 2'b01, "b2b_grant_1");
        step(1'b1, 1'b0, 2'b00, 2'b00, "b2b_swap_idle");
        step(1'b1, 1'b0, 2'b10, 2'b10, "b2b_grant_0");
        step(1'b0, 1'b0, 2'b00, 2'b00, "b2b_release");
    endtask

    task automatic test_async_reset();
        logic [3:0] exp;
        do_reset();
        step(1'b0, 1'b1, 2'b01, 2'b01, "async_grant");
        step(1'b0, 1'b1, 2'b01, 2'b01, "async_keep");
        #2;
        sb_q.push_back(4'b0000);
        rst = 1'b0;
        #1;
        exp = sb_q.pop_front();
        checks = checks + 1;
        if ({gnt_0_m, gnt_1_m, gnt_0_h, gnt_1_h} !== exp) begin
            errors = errors + 1;
            $display("FAIL async_drop t=%0t got %b%b%b%b expected %b", $time,
                     gnt_0_m, gnt_1_m, gnt_0_h, gnt_1_h, exp);
        end
        step(1'b0, 1'b1, 2'b00, 2'b00, "async_held");
        rst = 1'b1;
        step(1'b0, 1'b1, 2'b01, 2'b01, "async_regrant");
        step(1'b0, 1'b0, 2'b00, 2'b00, "async_release");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        req_0  = 1'b0;
        req_1  = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_tie();
        test_hold();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
